// File: rtl/jtag_axi_master_ctrl.sv
// Single-beat AXI4-Lite master driven by the JTAG management register (tck domain).
// Optional JTAG_AXI_TIMEOUT_EN aborts any transaction that runs TIMEOUT_CYCLES without a response.
module jtag_axi_master_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                    tck,
  input  logic                    trstn,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   txn_addr,
  input  logic [DATA_WIDTH-1:0]   txn_wdata,
  input  logic                    txn_write,
  input  logic [2:0]              txn_size,
  output logic                    busy,
  output logic                    done,
  output logic [2:0]              status,
  output logic [DATA_WIDTH-1:0]   rdata_out,
  output logic                    start_dropped,
  output logic [ADDR_WIDTH-1:0]   m_awaddr,
  output logic                    m_awvalid,
  input  logic                    m_awready,
  output logic [2:0]              m_awprot,
  output logic [DATA_WIDTH-1:0]   m_wdata,
  output logic [DATA_WIDTH/8-1:0] m_wstrb,
  output logic                    m_wvalid,
  input  logic                    m_wready,
  input  logic [1:0]              m_bresp,
  input  logic                    m_bvalid,
  output logic                    m_bready,
  output logic [ADDR_WIDTH-1:0]   m_araddr,
  output logic                    m_arvalid,
  input  logic                    m_arready,
  output logic [2:0]              m_arprot,
  input  logic [DATA_WIDTH-1:0]   m_rdata,
  input  logic [1:0]              m_rresp,
  input  logic                    m_rvalid,
  output logic                    m_rready
);
  localparam int STRB_W = DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_RESP = 3'd4
  } state_t;

  state_t     state_r;
  logic       aw_done_r;
  logic       w_done_r;
  logic [1:0] size_s;
  logic       aligned_s;
  logic       aw_hs_s;
  logic       w_hs_s;
  logic       complete_s;
  logic       timeout_s;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  function automatic logic [1:0] clamp_size_f(input logic [2:0] sz);
    clamp_size_f = (sz > 3'd2) ? 2'd2 : sz[1:0];
  endfunction

  function automatic logic aligned_f(input logic [1:0] sz, input logic [1:0] lo);
    case (sz)
      2'd0:    aligned_f = 1'b1;
      2'd1:    aligned_f = ~lo[0];
      default: aligned_f = (lo == 2'b00);
    endcase
  endfunction

  function automatic logic [STRB_W-1:0] strb_f(input logic [1:0] sz, input logic [1:0] lo);
    logic [STRB_W-1:0] base;
    case (sz)
      2'd0:    base = STRB_W'(4'b0001);
      2'd1:    base = STRB_W'(4'b0011);
      default: base = STRB_W'(4'b1111);
    endcase
    strb_f = base << lo;
  endfunction

`ifdef JTAG_AXI_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt_r;

  // Cycle counter for the current transaction, cleared whenever the FSM is idle
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else if (state_r == IDLE) begin
      to_cnt_r <= {CNT_W{1'b0}};
    end else begin
      to_cnt_r <= to_cnt_r + CNT_W'(1);
    end
  end
`endif

  // Request decode, handshake detection and abort condition
  always_comb begin
    size_s     = clamp_size_f(txn_size);
    aligned_s  = aligned_f(size_s, txn_addr[1:0]);
    aw_hs_s    = m_awvalid & m_awready;
    w_hs_s     = m_wvalid & m_wready;
    complete_s = ((state_r == WR_RESP) & m_bvalid) | ((state_r == RD_RESP) & m_rvalid);
    timeout_s  = 1'b0;
`ifdef JTAG_AXI_TIMEOUT_EN
    if ((state_r != IDLE) && (to_cnt_r == CNT_W'(TIMEOUT_CYCLES - 1))) begin
      timeout_s = 1'b1;
    end else begin
      timeout_s = 1'b0;
    end
`endif
  end

  assign m_awprot = 3'b000;
  assign m_arprot = 3'b000;

  // Transaction sequencer with registered bus and status outputs
  always_ff @(posedge tck or negedge trstn) begin
    if (!trstn) begin
      state_r       <= IDLE;
      aw_done_r     <= 1'b0;
      w_done_r      <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      status        <= 3'd0;
      rdata_out     <= {DATA_WIDTH{1'b0}};
      start_dropped <= 1'b0;
      m_awaddr      <= {ADDR_WIDTH{1'b0}};
      m_araddr      <= {ADDR_WIDTH{1'b0}};
      m_wdata       <= {DATA_WIDTH{1'b0}};
      m_wstrb       <= {STRB_W{1'b0}};
      m_awvalid     <= 1'b0;
      m_wvalid      <= 1'b0;
      m_bready      <= 1'b0;
      m_arvalid     <= 1'b0;
      m_rready      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (timeout_s && !complete_s) begin
        // Debug recovery: valids are withdrawn without a handshake
        m_awvalid <= 1'b0;
        m_wvalid  <= 1'b0;
        m_bready  <= 1'b0;
        m_arvalid <= 1'b0;
        m_rready  <= 1'b0;
        status    <= 3'd6;
        done      <= 1'b1;
        busy      <= 1'b0;
        state_r   <= IDLE;
      end else begin
        case (state_r)
          IDLE: begin
            if (start) begin
              m_awaddr <= txn_addr;
              m_araddr <= txn_addr;
              m_wdata  <= txn_wdata;
              m_wstrb  <= strb_f(size_s, txn_addr[1:0]);
              if (!aligned_s) begin
                status <= 3'd7;
                done   <= 1'b1;
              end else begin
                status        <= 3'd1;
                busy          <= 1'b1;
                start_dropped <= 1'b0;
                aw_done_r     <= 1'b0;
                w_done_r      <= 1'b0;
                if (txn_write) begin
                  m_awvalid <= 1'b1;
                  m_wvalid  <= 1'b1;
                  state_r   <= WR_REQ;
                end else begin
                  m_arvalid <= 1'b1;
                  state_r   <= RD_REQ;
                end
              end
            end
          end
          WR_REQ: begin
            if (aw_hs_s) begin
              m_awvalid <= 1'b0;
              aw_done_r <= 1'b1;
            end
            if (w_hs_s) begin
              m_wvalid <= 1'b0;
              w_done_r <= 1'b1;
            end
            if ((aw_done_r | aw_hs_s) && (w_done_r | w_hs_s)) begin
              m_bready <= 1'b1;
              state_r  <= WR_RESP;
            end
          end
          WR_RESP: begin
            if (m_bvalid) begin
              m_bready <= 1'b0;
              status   <= 3'd2 + {1'b0, m_bresp};
              done     <= 1'b1;
              busy     <= 1'b0;
              state_r  <= IDLE;
            end
          end
          RD_REQ: begin
            if (m_arready) begin
              m_arvalid <= 1'b0;
              m_rready  <= 1'b1;
              state_r   <= RD_RESP;
            end
          end
          RD_RESP: begin
            if (m_rvalid) begin
              m_rready  <= 1'b0;
              rdata_out <= m_rdata;
              status    <= 3'd2 + {1'b0, m_rresp};
              done      <= 1'b1;
              busy      <= 1'b0;
              state_r   <= IDLE;
            end
          end
          default: begin
            state_r <= IDLE;
          end
        endcase
      end
      if (start && (state_r != IDLE)) begin
        start_dropped <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_jtag_axi_master_ctrl.sv
// Scoreboard bench for jtag_axi_master_ctrl: directed transactions against a configurable AXI slave.
module tb_jtag_axi_master_ctrl;
  localparam int TO = 16;

  logic        tck = 1'b0;
  logic        trstn = 1'b0;
  logic        start = 1'b0;
  logic [31:0] txn_addr = 32'h0;
  logic [31:0] txn_wdata = 32'h0;
  logic        txn_write = 1'b0;
  logic [2:0]  txn_size = 3'd0;
  logic        busy, done, start_dropped;
  logic [2:0]  status;
  logic [31:0] rdata_out;
  logic [31:0] m_awaddr, m_araddr, m_wdata;
  logic [3:0]  m_wstrb;
  logic [2:0]  m_awprot, m_arprot;
  logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0, m_arready = 1'b0, m_rvalid = 1'b0;
  logic [1:0]  m_bresp = 2'd0, m_rresp = 2'd0;
  logic [31:0] m_rdata = 32'h0;

  jtag_axi_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .tck(tck), .trstn(trstn), .start(start), .txn_addr(txn_addr), .txn_wdata(txn_wdata),
    .txn_write(txn_write), .txn_size(txn_size), .busy(busy), .done(done), .status(status),
    .rdata_out(rdata_out), .start_dropped(start_dropped),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awprot(m_awprot),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arprot(m_arprot),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
  );

  always #5 tck = ~tck;

  typedef struct {
    string       name;
    bit          wr;
    int          status;
    logic [31:0] rdata;
    int          strb;
    longint      addr;
    longint      wdata;
    int          awc, wc, arc, bph, lat;
  } exp_t;

  exp_t        q[$];
  int          n_chk = 0, n_pass = 0, done_cnt = 0, cyc = 0, start_cyc = 0;
  int          aw_tot = 0, w_tot = 0, ar_tot = 0, bph_tot = 0;
  int          aw_base = 0, w_base = 0, ar_base = 0, bph_base = 0;
  int          aw_dly = 0, w_dly = 0, ar_dly = 0;
  logic [1:0]  s_resp = 2'd0;
  logic [31:0] s_rdata = 32'h0;
  bit          b_never = 1'b0;
  logic [31:0] cap_awaddr = 32'h0, cap_araddr = 32'h0, cap_wdata = 32'h0;
  logic [3:0]  cap_wstrb = 4'h0;
  logic [31:0] model_rdata = 32'h0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  always @(posedge tck) cyc++;

  // AXI slave model: programmable ready delays, fixed response, records handshakes
  int   aw_cnt = 0, w_cnt = 0, ar_cnt = 0;
  logic bready_q = 1'b0;
  always @(negedge tck) begin
    if (m_awvalid) begin
      m_awready = (aw_cnt >= aw_dly); aw_cnt++; aw_tot++;
      if (m_awready) cap_awaddr = m_awaddr;
    end else begin
      m_awready = 1'b0; aw_cnt = 0;
    end
    if (m_wvalid) begin
      m_wready = (w_cnt >= w_dly); w_cnt++; w_tot++;
      if (m_wready) begin cap_wdata = m_wdata; cap_wstrb = m_wstrb; end
    end else begin
      m_wready = 1'b0; w_cnt = 0;
    end
    if (m_arvalid) begin
      m_arready = (ar_cnt >= ar_dly); ar_cnt++; ar_tot++;
      if (m_arready) cap_araddr = m_araddr;
    end else begin
      m_arready = 1'b0; ar_cnt = 0;
    end
    m_bvalid = m_bready && !b_never;
    m_bresp  = s_resp;
    m_rvalid = m_rready;
    m_rresp  = s_resp;
    m_rdata  = m_rready ? s_rdata : 32'h0;
    if (m_bready && !bready_q) bph_tot++;
    bready_q = m_bready;
  end

  // Monitor: every done pulse pops one expectation
  always @(negedge tck) begin
    exp_t e;
    if (trstn && done) begin
      done_cnt++;
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got status %0d, expected no completion", status);
      end else begin
        e = q.pop_front();
        check({e.name, "_status"}, longint'(status), longint'(e.status));
        check({e.name, "_busy"}, longint'(busy), 64'd0);
        check({e.name, "_rdata"}, longint'(rdata_out), longint'(e.rdata));
        if (e.strb >= 0) check({e.name, "_wstrb"}, longint'(cap_wstrb), longint'(e.strb));
        if (e.addr >= 0) check({e.name, "_addr"}, longint'(e.wr ? cap_awaddr : cap_araddr), e.addr);
        if (e.wdata >= 0) check({e.name, "_wdata"}, longint'(cap_wdata), e.wdata);
        check({e.name, "_aw_cycles"}, longint'(aw_tot - aw_base), longint'(e.awc));
        check({e.name, "_w_cycles"}, longint'(w_tot - w_base), longint'(e.wc));
        check({e.name, "_ar_cycles"}, longint'(ar_tot - ar_base), longint'(e.arc));
        check({e.name, "_bready_phases"}, longint'(bph_tot - bph_base), longint'(e.bph));
        check({e.name, "_latency"}, longint'(cyc - start_cyc), longint'(e.lat));
      end
    end
  end

  task automatic run(input string nm, input logic [31:0] a, input logic [31:0] d, input logic wr,
                     input logic [2:0] sz, input int awd, input int wd, input int ard,
                     input logic [1:0] resp, input logic [31:0] rd, input int est, input int estrb,
                     input int eawc, input int ewc, input int earc, input int ebph, input int elat,
                     input int drop_at);
    exp_t e;
    int   base;
    aw_dly = awd; w_dly = wd; ar_dly = ard; s_resp = resp; s_rdata = rd;
    if (!wr && est != 7 && est != 6) model_rdata = rd;
    e.name = nm; e.wr = wr; e.status = est; e.rdata = model_rdata; e.strb = estrb;
    e.addr = (est == 7) ? -64'sd1 : longint'(a);
    e.wdata = (wr && est != 7) ? longint'(d) : -64'sd1;
    e.awc = eawc; e.wc = ewc; e.arc = earc; e.bph = ebph; e.lat = elat;
    q.push_back(e);
    @(negedge tck);
    aw_base = aw_tot; w_base = w_tot; ar_base = ar_tot; bph_base = bph_tot;
    base = done_cnt; start_cyc = cyc;
    txn_addr = a; txn_wdata = d; txn_write = wr; txn_size = sz; start = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge tck);
      if (done_cnt != base) break;
      start = (i == drop_at);
      if (i == drop_at) begin
        check({nm, "_running_status"}, longint'(status), 64'd1);
        check({nm, "_running_busy"}, longint'(busy), 64'd1);
        txn_addr = 32'h5555_0000; txn_wdata = 32'h0BAD_0BAD; txn_write = 1'b1;
      end
    end
    start = 1'b0;
    @(negedge tck);
    if (done_cnt == base) begin
      n_chk++;
      $display("FAIL %s_timeout: got no done within 300 cycles, expected a done pulse", nm);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge tck);
    check("rst_busy", longint'(busy), 64'd0);
    check("rst_done", longint'(done), 64'd0);
    check("rst_status", longint'(status), 64'd0);
    check("rst_valids", longint'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 64'd0);
    check("rst_addr_strb", longint'({m_awaddr, m_wstrb}), 64'd0);
    check("rst_rdata_dropped", longint'({rdata_out, start_dropped}), 64'd0);
    trstn = 1'b1;
    repeat (2) @(negedge tck);

    //  name        addr          wdata         wr    sz    awd wd ard resp rdata         st strb awc wc arc bph lat drop
    run("wr_word",  32'h1000_0000, 32'hDEAD_BEEF, 1'b1, 3'd2, 0, 0, 0, 2'd0, 32'h0,        2, 15,  1, 1, 0, 1, 3, -1);
    run("wr_byte",  32'h1000_0003, 32'h0000_00AB, 1'b1, 3'd0, 0, 0, 0, 2'd0, 32'h0,        2, 8,   1, 1, 0, 1, 3, -1);
    run("wr_half",  32'h1000_0002, 32'hBEEF_0000, 1'b1, 3'd1, 0, 0, 0, 2'd0, 32'h0,        2, 12,  1, 1, 0, 1, 3, -1);
    run("wr_size5", 32'h1000_0004, 32'h1122_3344, 1'b1, 3'd5, 0, 0, 0, 2'd0, 32'h0,        2, 15,  1, 1, 0, 1, 3, -1);
    run("rd_slverr",32'h2000_0000, 32'h0,         1'b0, 3'd2, 0, 0, 4, 2'd2, 32'hCAFE_F00D, 4, -1,  0, 0, 5, 0, 7, -1);
    run("wr_wfirst",32'h1000_0008, 32'h55AA_55AA, 1'b1, 3'd2, 3, 0, 0, 2'd0, 32'h0,        2, 15,  4, 1, 0, 1, 6, -1);
    run("wr_exokay",32'h1000_000C, 32'h0102_0304, 1'b1, 3'd2, 0, 0, 0, 2'd1, 32'h0,        3, 15,  1, 1, 0, 1, 3, -1);
    run("wr_align", 32'h1000_0001, 32'h7777_7777, 1'b1, 3'd1, 0, 0, 0, 2'd0, 32'h0,        7, -1,  0, 0, 0, 0, 1, -1);
    run("rd_drop",  32'h3000_0010, 32'h0,         1'b0, 3'd2, 0, 0, 6, 2'd0, 32'h1234_5678, 2, -1,  0, 0, 7, 0, 9, 2);
    check("start_dropped_set", longint'(start_dropped), 64'd1);
    repeat (3) @(negedge tck);
    check("status_holds", longint'(status), 64'd2);
    run("rd_decerr",32'h2000_0040, 32'h0,         1'b0, 3'd2, 0, 0, 0, 2'd3, 32'h0BAD_F00D, 5, -1,  0, 0, 1, 0, 3, -1);
    check("start_dropped_clear", longint'(start_dropped), 64'd0);
`ifdef JTAG_AXI_TIMEOUT_EN
    b_never = 1'b1;
    run("wr_timeout",32'h1000_0010, 32'hABCD_0123, 1'b1, 3'd2, 0, 0, 0, 2'd0, 32'h0,       6, 15,  1, 1, 0, 1, TO + 1, -1);
    check("timeout_bready_low", longint'(m_bready), 64'd0);
    b_never = 1'b0;
    repeat (2) @(negedge tck);
`endif

    // Reset in the middle of a read: outputs return to reset values, no completion
    ar_dly = 10;
    @(negedge tck);
    txn_addr = 32'h2000_0080; txn_write = 1'b0; txn_size = 3'd2; start = 1'b1;
    @(negedge tck);
    start = 1'b0;
    repeat (3) @(negedge tck);
    check("midrd_arvalid_before", longint'(m_arvalid), 64'd1);
    trstn = 1'b0;
    #1;
    check("midrd_busy", longint'(busy), 64'd0);
    check("midrd_valids", longint'({m_awvalid, m_wvalid, m_arvalid, m_bready, m_rready}), 64'd0);
    check("midrd_status", longint'(status), 64'd0);
    check("midrd_rdata", longint'(rdata_out), 64'd0);
    check("midrd_araddr", longint'(m_araddr), 64'd0);
    @(negedge tck);
    trstn = 1'b1;
    model_rdata = 32'h0;
    repeat (15) @(negedge tck);
    run("rd_after", 32'h2000_0100, 32'h0,         1'b0, 3'd2, 0, 0, 0, 2'd0, 32'hA5A5_0001, 2, -1,  0, 0, 1, 0, 3, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
